// File: rtl/i2s_rx_ctrl.sv
// Frame sequencer for i2s_receiver: LRCK lock monitor, start/stop sequencing and a valid/ready sample register.
// Optional I2S_RX_CTRL_MUTE_ON_UNLOCK_EN zeroes held/captured samples whenever LRCK lock is absent.
module i2s_rx_ctrl #(
  parameter int DATA_W        = 24,
  parameter int BICK_PER_HALF = 40,
  parameter int LOCK_FRAMES   = 4,
  parameter int TIMEOUT_SLACK = 8
) (
  input  logic              bick,
  input  logic              reset,
  input  logic              enable,
  input  logic              lrck,
  output logic              rx_start,
  input  logic              rx_stop,
  input  logic [DATA_W-1:0] rx_data_left,
  input  logic [DATA_W-1:0] rx_data_right,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              locked,
  output logic              overflow,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int HALF_MAX  = 2 * BICK_PER_HALF;
  localparam int TMO_LIMIT = HALF_MAX + TIMEOUT_SLACK;
  localparam int HALF_W    = $clog2(HALF_MAX + 1);
  localparam int GOOD_W    = $clog2(LOCK_FRAMES + 1);
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  localparam logic [HALF_W-1:0] HALF_ONE   = HALF_W'(1);
  localparam logic [HALF_W-1:0] HALF_MATCH = HALF_W'(BICK_PER_HALF);
  localparam logic [HALF_W-1:0] HALF_SAT   = HALF_W'(HALF_MAX);
  localparam logic [GOOD_W-1:0] GOOD_FULL  = GOOD_W'(LOCK_FRAMES);
  localparam logic [TMO_W-1:0]  TMO_ONE    = TMO_W'(1);
  // tmo_cnt holds the number of cycles since the start pulse, so the flag lands TMO_LIMIT cycles after it
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    START,
    RECEIVE
  } state_t;

  state_t              state;
  logic                lrck_q;
  logic [HALF_W-1:0]   half_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  logic [TMO_W-1:0]    tmo_cnt;

  logic                lrck_fall;
  logic                lrck_edge;
  logic                half_match;
  logic                half_sat;
  logic                lock_clr;
  logic                capture;
  logic                transfer;
  logic [DATA_W-1:0]   cap_left;
  logic [DATA_W-1:0]   cap_right;

  assign lrck_fall  = lrck_q & ~lrck;
  assign lrck_edge  = lrck_q ^ lrck;
  assign half_match = (half_cnt == HALF_MATCH);
  assign half_sat   = (half_cnt == HALF_SAT);
  // Lock is lost on a mismatched half-period or when LRCK has stopped long enough to saturate the counter
  assign lock_clr   = lrck_edge ? ~half_match : half_sat;

  assign capture    = (state == RECEIVE) & locked & rx_stop;
  assign transfer   = sample_valid & sample_ready;

`ifdef I2S_RX_CTRL_MUTE_ON_UNLOCK_EN
  assign cap_left   = locked ? rx_data_left  : '0;
  assign cap_right  = locked ? rx_data_right : '0;
`else
  assign cap_left   = rx_data_left;
  assign cap_right  = rx_data_right;
`endif

  always_ff @(posedge bick) begin
    if (reset) begin
      lrck_q   <= 1'b0;
      half_cnt <= '0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lrck_q <= lrck;
      if (lrck_edge) begin
        half_cnt <= HALF_ONE;
      end else if (!half_sat) begin
        half_cnt <= half_cnt + HALF_ONE;
      end
      if (lock_clr) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        if (lrck_edge && (good_cnt != GOOD_FULL)) begin
          good_cnt <= good_cnt + 1'b1;
        end
        if (good_cnt == GOOD_FULL) begin
          locked <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge bick) begin
    if (reset) begin
      state       <= IDLE;
      rx_start    <= 1'b1;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      rx_start <= 1'b1;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (enable && locked) begin
            state <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          tmo_cnt <= '0;
          if (!enable || !locked) begin
            state <= IDLE;
          end else if (lrck_fall) begin
            state    <= START;
            rx_start <= 1'b0;
          end
        end
        START: begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
          state   <= RECEIVE;
        end
        RECEIVE: begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
          if (!locked) begin
            state <= IDLE;
          end else if (rx_stop) begin
            state <= enable ? WAIT_FRAME : IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= enable ? WAIT_FRAME : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Newest sample always wins; overflow only when a pending sample is overwritten without being taken
  always_ff @(posedge bick) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (capture) begin
        sample_left  <= cap_left;
        sample_right <= cap_right;
        sample_valid <= 1'b1;
      end else if (transfer) begin
        sample_valid <= 1'b0;
      end
`ifdef I2S_RX_CTRL_MUTE_ON_UNLOCK_EN
      if (locked && lock_clr && sample_valid) begin
        sample_left  <= '0;
        sample_right <= '0;
      end
`endif
      if (capture && sample_valid && !transfer) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl: lock acquisition, capture/overflow table, timeout, lock loss and reset.
module tb_i2s_rx_ctrl;
  localparam int DATA_W = 24;

  logic              bick;
  logic              reset;
  logic              enable;
  logic              lrck;
  logic              rx_start;
  logic              rx_stop;
  logic [DATA_W-1:0] rx_data_left;
  logic [DATA_W-1:0] rx_data_right;
  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              sample_valid;
  logic              sample_ready;
  logic              locked;
  logic              overflow;
  logic              timeout_err;
  logic              err_clr;

  int checks;
  int failures;
  int cyc;
  int lr_cnt;
  int half_len;
  int last_fall_cyc;
  bit lr_run;
  int toggle_cycs[$];

  typedef struct {
    int          stop_delay;
    logic        ready;
    logic        clr_before;
    logic [23:0] left;
    logic [23:0] right;
    logic        exp_valid;
    logic [23:0] exp_left;
    logic [23:0] exp_right;
    logic        exp_overflow;
    logic        exp_valid_next;
  } vec_t;

  vec_t vecs[4];

  i2s_rx_ctrl #(
    .DATA_W(24),
    .BICK_PER_HALF(40),
    .LOCK_FRAMES(4),
    .TIMEOUT_SLACK(8)
  ) dut (
    .bick(bick),
    .reset(reset),
    .enable(enable),
    .lrck(lrck),
    .rx_start(rx_start),
    .rx_stop(rx_stop),
    .rx_data_left(rx_data_left),
    .rx_data_right(rx_data_right),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .locked(locked),
    .overflow(overflow),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial bick = 1'b0;
  always #10 bick = ~bick;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bick cycle; the LRCK source toggles every half_len cycles while running
  task automatic tick();
    @(posedge bick);
    #1;
    cyc++;
    if (lr_run) begin
      lr_cnt++;
      if (lr_cnt >= half_len) begin
        lr_cnt = 0;
        lrck   = ~lrck;
        toggle_cycs.push_back(cyc);
        if (!lrck) last_fall_cyc = cyc;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rx_start === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no rx_start pulse expected one within 300 cycles", name);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bit ok;
    if (v.clr_before) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput($sformatf("v%0d_clr_overflow", idx), 32'(overflow), 32'd0);
    end
    wait_start($sformatf("v%0d_start", idx), ok);
    if (!ok) return;
    checkOutput($sformatf("v%0d_start_latency", idx), cyc, last_fall_cyc + 1);
    tick();
    checkOutput($sformatf("v%0d_start_width", idx), 32'(rx_start), 32'd1);
    repeat (v.stop_delay - 1) tick();
    rx_stop       = 1'b1;
    rx_data_left  = v.left;
    rx_data_right = v.right;
    sample_ready  = v.ready;
    tick();
    rx_stop = 1'b0;
    checkOutput($sformatf("v%0d_valid", idx), 32'(sample_valid), 32'(v.exp_valid));
    checkOutput($sformatf("v%0d_left", idx), 32'(sample_left), 32'(v.exp_left));
    checkOutput($sformatf("v%0d_right", idx), 32'(sample_right), 32'(v.exp_right));
    checkOutput($sformatf("v%0d_overflow", idx), 32'(overflow), 32'(v.exp_overflow));
    tick();
    checkOutput($sformatf("v%0d_valid_next", idx), 32'(sample_valid), 32'(v.exp_valid_next));
  endtask

  initial begin
    bit ok;
    bit saw_start;
    int s_cyc;
    int base;
    int lock_cyc;
    int exp_cyc;

    vecs[0] = '{stop_delay: 60, ready: 1'b1, clr_before: 1'b0, left: 24'hABCDEF, right: 24'h123456,
                exp_valid: 1'b1, exp_left: 24'hABCDEF, exp_right: 24'h123456, exp_overflow: 1'b0, exp_valid_next: 1'b0};
    vecs[1] = '{stop_delay: 60, ready: 1'b0, clr_before: 1'b0, left: 24'h000001, right: 24'h00000A,
                exp_valid: 1'b1, exp_left: 24'h000001, exp_right: 24'h00000A, exp_overflow: 1'b0, exp_valid_next: 1'b1};
    vecs[2] = '{stop_delay: 60, ready: 1'b0, clr_before: 1'b0, left: 24'h000002, right: 24'h00000B,
                exp_valid: 1'b1, exp_left: 24'h000002, exp_right: 24'h00000B, exp_overflow: 1'b1, exp_valid_next: 1'b1};
    vecs[3] = '{stop_delay: 10, ready: 1'b1, clr_before: 1'b1, left: 24'h5A5A5A, right: 24'hA5A5A5,
                exp_valid: 1'b1, exp_left: 24'h5A5A5A, exp_right: 24'hA5A5A5, exp_overflow: 1'b0, exp_valid_next: 1'b0};

    checks        = 0;
    failures      = 0;
    cyc           = 0;
    lr_cnt        = 0;
    half_len      = 40;
    last_fall_cyc = -100;
    lr_run        = 1'b0;
    reset         = 1'b1;
    enable        = 1'b1;
    lrck          = 1'b0;
    rx_stop       = 1'b0;
    rx_data_left  = '0;
    rx_data_right = '0;
    sample_ready  = 1'b0;
    err_clr       = 1'b0;

    tick();
    tick();
    checkOutput("rst_rx_start", 32'(rx_start), 32'd1);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_left", 32'(sample_left), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);

    // Lock acquisition: four matching half-periods, locked two cycles after the 4th toggle
    reset  = 1'b0;
    lr_run = 1'b1;
    lock_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (locked === 1'b1) begin
        lock_cyc = cyc;
        break;
      end
    end
    exp_cyc = (toggle_cycs.size() >= 4) ? toggle_cycs[3] + 2 : -2;
    checkOutput("lock_rise_cycle", lock_cyc, exp_cyc);

    $display("[TB] applying capture vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Timeout: no rx_stop, flag exactly 88 cycles after the pulse, next frame still started
    wait_start("tmo_start", ok);
    s_cyc = cyc;
    lock_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (timeout_err === 1'b1) begin
        lock_cyc = cyc;
        break;
      end
    end
    checkOutput("timeout_cycle", lock_cyc, s_cyc + 88);
    checkOutput("timeout_no_capture", 32'(sample_valid), 32'd0);
    wait_start("tmo_next_start", ok);
    if (ok) checkOutput("tmo_next_start_latency", cyc, last_fall_cyc + 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("timeout_clr", 32'(timeout_err), 32'd0);

    // Lock loss mid-RECEIVE: half-period shortened to 37
    half_len = 37;
    base = toggle_cycs.size();
    for (int i = 0; i < 80 && toggle_cycs.size() == base; i++) tick();
    checkOutput("locked_before_bad_edge", 32'(locked), 32'd1);
    tick();
    checkOutput("lock_drop", 32'(locked), 32'd0);
    rx_stop       = 1'b1;
    rx_data_left  = 24'hFFFFFF;
    rx_data_right = 24'hFFFFFF;
    tick();
    rx_stop = 1'b0;
    checkOutput("lost_no_capture_valid", 32'(sample_valid), 32'd0);
    checkOutput("lost_no_capture_left", 32'(sample_left), 32'h5A5A5A);

    saw_start = 1'b0;
    base = toggle_cycs.size();
    for (int i = 0; i < 200 && toggle_cycs.size() < base + 2; i++) begin
      tick();
      if (rx_start === 1'b0) saw_start = 1'b1;
    end
    half_len = 40;
    base = toggle_cycs.size();
    lock_cyc = -1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (rx_start === 1'b0) saw_start = 1'b1;
      if (locked === 1'b1) begin
        lock_cyc = cyc;
        break;
      end
    end
    exp_cyc = (toggle_cycs.size() >= base + 4) ? toggle_cycs[base + 3] + 2 : -2;
    checkOutput("relock_cycle", lock_cyc, exp_cyc);
    checkOutput("no_start_while_unlocked", 32'(saw_start), 32'd0);

    // Reset mid-RECEIVE
    wait_start("rst_start", ok);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_rx_start", 32'(rx_start), 32'd1);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_valid", 32'(sample_valid), 32'd0);
    checkOutput("midrst_left", 32'(sample_left), 32'd0);
    checkOutput("midrst_right", 32'(sample_right), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow), 32'd0);
    checkOutput("midrst_timeout", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("postrst_locked", 32'(locked), 32'd0);
    checkOutput("postrst_rx_start", 32'(rx_start), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
